// File: rtl/branch_ckpt_pkg.sv
// Shared types and helpers for the branch checkpoint controller.
// Optional perf counters are enabled with BRANCH_CKPT_PERF_EN.
package branch_ckpt_pkg;

    localparam int CKPT_DEPTH     = 4;
    localparam int CKPT_WIDTH     = 2;
    localparam int ROB_WIDTH      = 4;
    localparam int RECOVER_CYCLES = 2;
    localparam int STALL_W        = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } ckpt_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 resolved;
        logic [ROB_WIDTH-1:0] rob_tag;
    } ckpt_slot_t;

    typedef logic [CKPT_WIDTH-1:0] ckpt_id_t;
    typedef logic [CKPT_WIDTH:0]   ckpt_cnt_t;
    typedef logic [CKPT_DEPTH-1:0] ckpt_mask_t;

    // Slots from id up to tail-1 (modulo). id is a live slot, so
    // tail==id can only mean the FIFO is full: every slot goes.
    function automatic ckpt_mask_t squash_range(input ckpt_id_t id,
                                                input ckpt_id_t tail);
        ckpt_mask_t m;
        ckpt_id_t   span;
        ckpt_id_t   off;
        m    = '0;
        span = tail - id;
        for (int i = 0; i < CKPT_DEPTH; i++) begin
            off = ckpt_id_t'(i) - id;
            if (span == '0 || off < span) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ckpt_slot_fifo.sv
// Circular checkpoint slot store: allocation, resolve marking,
// in-order retirement and squash of a younger range.
module ckpt_slot_fifo
    import branch_ckpt_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_alloc,
    input  logic [ROB_WIDTH-1:0]  i_alloc_rob_tag,
    input  logic                  i_resolve,
    input  logic [CKPT_WIDTH-1:0] i_resolve_id,
    input  logic                  i_squash,
    input  logic [CKPT_WIDTH-1:0] i_squash_id,
    input  logic                  i_retire_en,
    output logic [CKPT_WIDTH-1:0] o_tail,
    output logic [CKPT_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic [CKPT_DEPTH-1:0] o_valid,
    output logic [ROB_WIDTH-1:0]  o_squash_tag,
    output logic [CKPT_DEPTH-1:0] o_squash_mask
);

    ckpt_slot_t r_slots [CKPT_DEPTH];
    ckpt_id_t   r_head;
    ckpt_id_t   r_tail;
    ckpt_cnt_t  r_count;

    logic       w_empty;
    logic       w_retire;
    ckpt_mask_t w_mask;

    assign w_empty       = (r_count == '0);
    assign o_full        = (r_count == ckpt_cnt_t'(CKPT_DEPTH));
    assign w_retire      = i_retire_en && !w_empty && r_slots[r_head].resolved;
    assign w_mask        = squash_range(i_squash_id, r_tail);
    assign o_tail        = r_tail;
    assign o_count       = r_count;
    assign o_squash_tag  = r_slots[i_squash_id].rob_tag;
    assign o_squash_mask = w_mask;

    // Flatten the per-slot valid bits for the controller.
    always_comb begin
        o_valid = '0;
        for (int i = 0; i < CKPT_DEPTH; i++) begin
            o_valid[i] = r_slots[i].valid;
        end
    end

    // Slot array and pointers; squash overrides alloc and retirement.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                r_slots[i] <= '0;
            end
        end else if (i_squash) begin
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                if (w_mask[i]) begin
                    r_slots[i] <= '0;
                end
            end
            r_tail  <= i_squash_id;
            r_count <= {1'b0, ckpt_id_t'(i_squash_id - r_head)};
        end else begin
            if (i_resolve && r_slots[i_resolve_id].valid) begin
                r_slots[i_resolve_id].resolved <= 1'b1;
            end
            if (i_alloc) begin
                r_slots[r_tail] <= '{valid: 1'b1, resolved: 1'b0,
                                     rob_tag: i_alloc_rob_tag};
                r_tail <= r_tail + ckpt_id_t'(1);
            end
            if (w_retire) begin
                r_slots[r_head] <= '0;
                r_head <= r_head + ckpt_id_t'(1);
            end
            r_count <= r_count + ckpt_cnt_t'(i_alloc) - ckpt_cnt_t'(w_retire);
        end
    end

endmodule

// File: rtl/branch_ckpt_ctrl.sv
// Branch checkpoint controller: slot allocation, mispredict recovery FSM.
// Define BRANCH_CKPT_PERF_EN to add saturating performance counters.
module branch_ckpt_ctrl
    import branch_ckpt_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_alloc_req,
    input  logic [ROB_WIDTH-1:0]  i_alloc_rob_tag,
    output logic                  o_alloc_ready,
    output logic                  o_alloc_grant,
    output logic [CKPT_WIDTH-1:0] o_alloc_ckpt_id,
    input  logic                  i_resolve_valid,
    input  logic [CKPT_WIDTH-1:0] i_resolve_ckpt_id,
    input  logic                  i_resolve_mispredict,
    output logic                  o_resolve_ready,
    output logic                  o_restore_valid,
    output logic [CKPT_WIDTH-1:0] o_restore_ckpt_id,
    output logic [ROB_WIDTH-1:0]  o_restore_rob_tag,
    output logic [CKPT_DEPTH-1:0] o_squash_mask,
    output logic                  o_rename_stall,
    output logic [CKPT_WIDTH:0]   o_ckpt_count
`ifdef BRANCH_CKPT_PERF_EN
    ,
    output logic [31:0]           o_perf_mispredicts,
    output logic [31:0]           o_perf_full_stalls,
    output logic [31:0]           o_perf_recover_cycles
`endif
);

    ckpt_state_e          r_state;
    ckpt_state_e          w_state_nxt;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic [STALL_W-1:0]   w_stall_nxt;

    logic                 w_idle;
    logic                 w_accept;
    logic                 w_mispredict;
    logic                 w_resolve_ok;
    logic                 w_full;
    ckpt_mask_t           w_valid;
    ckpt_mask_t           w_mask;
    logic [ROB_WIDTH-1:0] w_tag;

    assign w_idle          = (r_state == IDLE);
    assign w_accept        = i_resolve_valid && w_idle;
    assign w_mispredict    = w_accept && i_resolve_mispredict
                             && w_valid[i_resolve_ckpt_id];
    assign w_resolve_ok    = w_accept && !i_resolve_mispredict;
    assign o_alloc_ready   = w_idle && !w_full;
    assign o_alloc_grant   = i_alloc_req && o_alloc_ready && !w_mispredict;
    assign o_resolve_ready = w_idle;
    assign o_rename_stall  = (r_state == RECOVER);

    ckpt_slot_fifo u_fifo (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_alloc         (o_alloc_grant),
        .i_alloc_rob_tag (i_alloc_rob_tag),
        .i_resolve       (w_resolve_ok),
        .i_resolve_id    (i_resolve_ckpt_id),
        .i_squash        (w_mispredict),
        .i_squash_id     (i_resolve_ckpt_id),
        .i_retire_en     (w_idle && !w_mispredict),
        .o_tail          (o_alloc_ckpt_id),
        .o_count         (o_ckpt_count),
        .o_full          (w_full),
        .o_valid         (w_valid),
        .o_squash_tag    (w_tag),
        .o_squash_mask   (w_mask)
    );

    // State and stall-counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_nxt;
        end
    end

    // Next state: enter RECOVER on a mispredict, leave when count hits 0.
    always_comb begin
        w_state_nxt = r_state;
        w_stall_nxt = r_stall_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_mispredict) begin
                    w_state_nxt = RECOVER;
                    w_stall_nxt = STALL_W'(RECOVER_CYCLES - 1);
                end
            end
            RECOVER: begin
                if (r_stall_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_stall_nxt = r_stall_cnt - STALL_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // One-cycle restore pulse with the captured slot, tag and squash range.
    always_ff @(posedge i_clk) begin
        if (i_reset || !w_mispredict) begin
            o_restore_valid   <= 1'b0;
            o_restore_ckpt_id <= '0;
            o_restore_rob_tag <= '0;
            o_squash_mask     <= '0;
        end else begin
            o_restore_valid   <= 1'b1;
            o_restore_ckpt_id <= i_resolve_ckpt_id;
            o_restore_rob_tag <= w_tag;
            o_squash_mask     <= w_mask;
        end
    end

`ifdef BRANCH_CKPT_PERF_EN
    // Saturating event counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_perf_mispredicts    <= '0;
            o_perf_full_stalls    <= '0;
            o_perf_recover_cycles <= '0;
        end else begin
            if (w_mispredict && o_perf_mispredicts != '1) begin
                o_perf_mispredicts <= o_perf_mispredicts + 32'd1;
            end
            if (i_alloc_req && w_full && o_perf_full_stalls != '1) begin
                o_perf_full_stalls <= o_perf_full_stalls + 32'd1;
            end
            if (o_rename_stall && o_perf_recover_cycles != '1) begin
                o_perf_recover_cycles <= o_perf_recover_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// Directed and random bench for branch_ckpt_ctrl against a queue model.
// Honours BRANCH_CKPT_PERF_EN when the design is built with it.
module tb_branch_ckpt_ctrl;
    import branch_ckpt_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic [3:0] alloc_rob_tag;
    logic       alloc_ready, alloc_grant;
    logic [1:0] alloc_ckpt_id;
    logic       resolve_valid;
    logic [1:0] resolve_ckpt_id;
    logic       resolve_mispredict;
    logic       resolve_ready, restore_valid;
    logic [1:0] restore_ckpt_id;
    logic [3:0] restore_rob_tag;
    logic [3:0] squash_mask;
    logic       rename_stall;
    logic [2:0] ckpt_count;
`ifdef BRANCH_CKPT_PERF_EN
    logic [31:0] perf_mis, perf_full, perf_rec;
    int unsigned m_pm, m_pf, m_pr;
`endif

    always #5 clk = ~clk;

    branch_ckpt_ctrl dut (
        .i_clk                (clk),
        .i_reset              (rst),
        .i_alloc_req          (alloc_req),
        .i_alloc_rob_tag      (alloc_rob_tag),
        .o_alloc_ready        (alloc_ready),
        .o_alloc_grant        (alloc_grant),
        .o_alloc_ckpt_id      (alloc_ckpt_id),
        .i_resolve_valid      (resolve_valid),
        .i_resolve_ckpt_id    (resolve_ckpt_id),
        .i_resolve_mispredict (resolve_mispredict),
        .o_resolve_ready      (resolve_ready),
        .o_restore_valid      (restore_valid),
        .o_restore_ckpt_id    (restore_ckpt_id),
        .o_restore_rob_tag    (restore_rob_tag),
        .o_squash_mask        (squash_mask),
        .o_rename_stall       (rename_stall),
        .o_ckpt_count         (ckpt_count)
`ifdef BRANCH_CKPT_PERF_EN
        ,
        .o_perf_mispredicts    (perf_mis),
        .o_perf_full_stalls    (perf_full),
        .o_perf_recover_cycles (perf_rec)
`endif
    );

    // Reference model: in-flight branches in program order.
    typedef struct {
        int id;
        int tag;
        bit res;
    } ent_t;

    ent_t q[$];
    int   m_tail = 0;
    int   m_rec  = 0;
    int   m_rv   = 0;
    int   m_rid  = 0;
    int   m_rtag = 0;
    int   m_mask = 0;
    int   checks = 0;
    int   errors = 0;
    logic       g_grant;
    logic [1:0] g_id;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rs, input bit req, input int tag,
                        input bit rv, input int rid, input bit rmis);
        bit idle, ready, mis, grant, ret;
        int pos;
        @(negedge clk);
        rst                = rs;
        alloc_req          = req;
        alloc_rob_tag      = tag[3:0];
        resolve_valid      = rv;
        resolve_ckpt_id    = rid[1:0];
        resolve_mispredict = rmis;
        #1;
        idle  = (m_rec == 0);
        ready = idle && (q.size() < CKPT_DEPTH);
        pos   = -1;
        foreach (q[k]) if (q[k].id == rid) pos = k;
        mis   = rv && idle && rmis && (pos >= 0);
        grant = req && ready && !mis;
        chk("alloc_ready", alloc_ready, ready);
        chk("alloc_grant", alloc_grant, grant);
        chk("alloc_id", alloc_ckpt_id, m_tail);
        chk("resolve_ready", resolve_ready, idle);
        chk("rename_stall", rename_stall, !idle);
        chk("count", ckpt_count, q.size());
        chk("restore_valid", restore_valid, m_rv);
        chk("restore_id", restore_ckpt_id, m_rid);
        chk("restore_tag", restore_rob_tag, m_rtag);
        chk("squash_mask", squash_mask, m_mask);
`ifdef BRANCH_CKPT_PERF_EN
        chk("perf_mis", perf_mis, m_pm);
        chk("perf_full", perf_full, m_pf);
        chk("perf_rec", perf_rec, m_pr);
`endif
        g_grant = alloc_grant;
        g_id    = alloc_ckpt_id;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_tail = 0; m_rec = 0;
            m_rv = 0; m_rid = 0; m_rtag = 0; m_mask = 0;
`ifdef BRANCH_CKPT_PERF_EN
            m_pm = 0; m_pf = 0; m_pr = 0;
`endif
        end else begin
`ifdef BRANCH_CKPT_PERF_EN
            if (mis) m_pm++;
            if (req && q.size() == CKPT_DEPTH) m_pf++;
            if (!idle) m_pr++;
`endif
            if (mis) begin
                m_rv = 1; m_rid = rid; m_rtag = q[pos].tag; m_mask = 0;
                for (int k = pos; k < q.size(); k++) m_mask |= (1 << q[k].id);
                while (q.size() > pos) void'(q.pop_back());
                m_tail = rid;
                m_rec  = RECOVER_CYCLES;
            end else begin
                m_rv = 0; m_rid = 0; m_rtag = 0; m_mask = 0;
                if (!idle) begin
                    m_rec--;
                end else begin
                    ret = (q.size() > 0) && q[0].res;
                    if (rv && !rmis && pos >= 0) q[pos].res = 1;
                    if (ret) void'(q.pop_front());
                    if (grant) begin
                        q.push_back('{m_tail, tag & 15, 1'b0});
                        m_tail = (m_tail + 1) % CKPT_DEPTH;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++) step(0, 1, 3 + 2 * i, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; alloc_req = 0; alloc_rob_tag = 0;
        resolve_valid = 0; resolve_ckpt_id = 0; resolve_mispredict = 0;
        do_reset();
        chk("rst_count", ckpt_count, 0);
        chk("rst_aready", alloc_ready, 1);
        chk("rst_rready", resolve_ready, 1);
        chk("rst_stall", rename_stall, 0);
        chk("rst_rvalid", restore_valid, 0);

        // Fill all four slots, then a refused fifth request.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 3 + 2 * i, 0, 0, 0);
            chk("fill_grant", g_grant, 1);
            chk("fill_id", g_id, i);
        end
        chk("full_count", ckpt_count, 4);
        chk("full_ready", alloc_ready, 0);
        step(0, 1, 11, 0, 0, 0);
        chk("full_nogrant", g_grant, 0);

        // Out-of-order correct resolves retire in order.
        step(0, 0, 0, 1, 1, 0);
        chk("ooo_c1", ckpt_count, 4);
        step(0, 0, 0, 1, 0, 0);
        chk("ooo_c2", ckpt_count, 4);
        step(0, 0, 0, 0, 0, 0);
        chk("ooo_c3", ckpt_count, 3);
        step(0, 0, 0, 0, 0, 0);
        chk("ooo_c4", ckpt_count, 2);

        // Mispredict on slot 1 with slots 0..3 live.
        do_reset();
        fill4();
        step(0, 0, 0, 1, 1, 1);
        chk("mp1_rvalid", restore_valid, 1);
        chk("mp1_rid", restore_ckpt_id, 1);
        chk("mp1_rtag", restore_rob_tag, 5);
        chk("mp1_mask", squash_mask, 4'b1110);
        chk("mp1_count", ckpt_count, 1);
        chk("mp1_tail", alloc_ckpt_id, 1);
        chk("mp1_stall1", rename_stall, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("mp1_stall2", rename_stall, 1);
        chk("mp1_pulse", restore_valid, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("mp1_stall3", rename_stall, 0);

        // Mispredict on head beats a same-cycle allocation.
        do_reset();
        step(0, 1, 2, 0, 0, 0);
        step(0, 1, 4, 0, 0, 0);
        step(0, 1, 6, 1, 0, 1);
        chk("mp0_nogrant", g_grant, 0);
        chk("mp0_mask", squash_mask, 4'b0011);
        chk("mp0_count", ckpt_count, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 8, 0, 0, 0);
        chk("mp0_regrant", g_grant, 1);
        chk("mp0_reid", g_id, 0);

        // Wrapped occupancy: head=3, tail=1.
        do_reset();
        fill4();
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 2, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_count1", ckpt_count, 1);
        step(0, 1, 12, 0, 0, 0);
        chk("wrap_id", g_id, 0);
        step(0, 0, 0, 1, 0, 1);
        chk("wrap_mask", squash_mask, 4'b0001);
        chk("wrap_count", ckpt_count, 1);
        chk("wrap_tail", alloc_ckpt_id, 0);

        // Reset during the first recovery cycle.
        do_reset();
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 2, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("rr_stall", rename_stall, 0);
        chk("rr_count", ckpt_count, 0);
        chk("rr_ready", alloc_ready, 1);
`ifdef BRANCH_CKPT_PERF_EN
        chk("rr_pm", perf_mis, 0);
        chk("rr_pf", perf_full, 0);
        chk("rr_pr", perf_rec, 0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3), $urandom_range(0, 4) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_ckpt_ctrl.md
Name: branch_ckpt_ctrl

Overview:
- Controller that sequences branch checkpoints for the rename stage: map-table, free-list and ROB-allocator snapshots.
- Allocates checkpoint slots in program order on branch dispatch and stalls rename when no slot is free.
- Retires slots in order once their branches resolve correctly.
- On a mispredict, drives a timed recovery sequence: restore pulse, squash of younger checkpoints, rename stall.

Parameters:
- CKPT_DEPTH, 4, number of checkpoint slots (power of two).
- CKPT_WIDTH, 2, log2(CKPT_DEPTH); width of slot ids.
- ROB_WIDTH, 4, ROB tag width stored per slot.
- RECOVER_CYCLES, 2, rename-stall cycles per mispredict (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alloc_req  in  1  branch dispatch request (valid && is_branch).
- alloc_rob_tag  in  ROB_WIDTH  ROB tag of the dispatching branch.
- alloc_ready  out  1  slot available and controller in IDLE.
- alloc_grant  out  1  alloc_req && alloc_ready && !mispredict-this-cycle.
- alloc_ckpt_id  out  CKPT_WIDTH  slot id given to the branch; equals tail.
- resolve_valid  in  1  branch resolution from execute.
- resolve_ckpt_id  in  CKPT_WIDTH  slot of the resolving branch.
- resolve_mispredict  in  1  1 = mispredicted.
- resolve_ready  out  1  resolution accepted; high only in IDLE.
- restore_valid  out  1  one-cycle pulse: restore snapshots from restore_ckpt_id.
- restore_ckpt_id  out  CKPT_WIDTH  slot to restore.
- restore_rob_tag  out  ROB_WIDTH  stored ROB tag of the mispredicted branch.
- squash_mask  out  CKPT_DEPTH  slots invalidated by the recovery; valid with restore_valid.
- rename_stall  out  1  high while in RECOVER.
- ckpt_count  out  CKPT_WIDTH+1  number of occupied slots.

Behaviour:
Reset:
- head=0, tail=0, count=0; valid/resolved bits clear; state IDLE.
- All outputs 0 except alloc_ready=1 and resolve_ready=1.
- Reset mid-recovery aborts the recovery immediately.

Storage:
- Circular FIFO of slots: head = oldest, tail = next free.
- full = (count==CKPT_DEPTH); empty = (count==0).
- head and tail wrap modulo CKPT_DEPTH.

Allocate:
- On alloc_grant, at the next edge: slot[tail] gets valid=1, resolved=0, rob_tag; tail++; count++.
- alloc_ckpt_id and alloc_grant are combinational from current state.

Correct resolve (resolve_valid && resolve_ready && !resolve_mispredict):
- Sets resolved[id] at the next edge.
- Resolve to a slot with valid=0 is ignored.

Retire:
- Each IDLE cycle, if !empty && resolved[head]: clear the slot, head++, count--.
- At most one retirement per cycle; retirement happens the cycle after the resolve at the earliest.
- Out-of-order correct resolves wait until they reach head.

Mispredict (accepted in cycle T, target slot valid):
- Mispredict wins over same-cycle alloc: alloc_grant forced 0.
- At edge T, state -> RECOVER and stall counter = RECOVER_CYCLES-1.
- Slot id and all younger slots (id up to tail-1, modulo) are cleared; tail=id; count=(id-head) mod CKPT_DEPTH.
- Special case: if id==head, count=0.
- Same-cycle retirement is suppressed.
- Cycle T+1: restore_valid=1; restore_ckpt_id and restore_rob_tag registered; squash_mask holds the cleared slots; rename_stall=1.
- rename_stall stays high for T+1 through T+RECOVER_CYCLES.
- State returns to IDLE at T+RECOVER_CYCLES+1.
- Mispredict to an invalid slot is ignored.

During RECOVER:
- alloc_ready=0 and resolve_ready=0.
- Upstream holds resolve_valid until resolve_ready.
- No retirement.

FSM:
- IDLE -> RECOVER on an accepted mispredict.
- RECOVER -> IDLE when the stall counter reaches 0.

Boundaries:
- Full: alloc_ready=0; a same-cycle retirement does not free the slot for the same cycle's grant.
- Empty: retirement logic idle.
- Alloc and retire in the same cycle: count unchanged.

Optional Feature:
BRANCH_CKPT_PERF_EN:
- Defined: adds outputs perf_mispredicts[31:0], perf_full_stalls[31:0] (cycles with alloc_req && full) and perf_recover_cycles[31:0].
- Counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package branch_ckpt_pkg holds:
  - ckpt_state_e {IDLE, RECOVER};
  - slot struct {valid, resolved, rob_tag};
  - typedef for slot-id arithmetic;
  - shared mask helper function squash_range(id, tail).
- One sub-module: ckpt_slot_fifo, covering head/tail/count, slot array and retirement. The top holds the FSM, recovery and the optional counters.

Test Plan:
- Reset, then 4 alloc_req with tags 3,5,7,9 -> ids 0,1,2,3; ckpt_count=4; alloc_ready=0; a 5th request gets no grant.
- Correct resolve id1 then id0 -> no retirement until id0 resolves; head advances over 2 consecutive cycles; count 4->3->2.
- Slots 0..3 live with head=0; mispredict id1 -> next cycle restore_valid=1, restore_ckpt_id=1, restore_rob_tag=5, squash_mask=4'b1110; count=1; tail=1; rename_stall high 2 cycles.
- Same cycle: mispredict id0 and alloc_req -> alloc_grant=0; squash_mask=all valid slots; count=0; the next grant after RECOVER returns id0.
- Wrap: head=3, tail=1 (slots 3,0 live); mispredict id0 -> squash_mask=4'b0001; count=1; tail=0.
- Reset asserted in the first RECOVER cycle -> next cycle rename_stall=0, count=0, alloc_ready=1; with BRANCH_CKPT_PERF_EN defined, all perf counters read 0.
